ram_access_master: RTL and testbench

- Bus initiator for the word-wide RAM slave interface (CE/RD/WR/ADDR/DATA).
- Converts CPU load/store requests (byte, half, word; signed or unsigned loads) into RAM bus cycles.
- Sub-word stores use read-modify-write, because the RAM writes whole 32-bit words only.
- Sits between the core's memory stage and the RAM.

---
 rtl/ram_access_pkg.sv | 28 ++
 rtl/ram_access_master_lane_align.sv | 60 ++++++
 rtl/ram_access_master.sv | 170 +++++++++++++++++
 tb/tb_ram_access_master.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_pkg.sv
// ram_access_pkg: shared definitions for the RAM access master slice.
//   - state_t     : FSM state encoding (IDLE, READ, WRITE, DONE)
//   - SZ_*        : LSU access size codes
//   - RAM_*_DEF   : default RAM window origin/length in bytes
//   - misaligned(): natural-alignment check for an access size/offset
package ram_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [31:0] RAM_ORIGIN_DEF = 32'h0000_0400;
  localparam logic [31:0] RAM_LENGTH_DEF = 32'h0000_0100;

  // Halves must sit on even addresses, words on multiples of four.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ram_access_master_lane_align.sv
// ram_lane_align: combinational byte-lane steering between 32-bit RAM words
// and right-justified LSU data.
//   iWORD     in  32  word read from RAM
//   iOFFSET   in  2   byte offset within the word (addr[1:0])
//   iSIZE     in  2   access size code
//   iUNSIGNED in  1   zero-extend (1) or sign-extend (0) loads
//   iWDATA    in  32  right-justified store data
//   oRDATA    out 32  selected lane, extended to 32 bits
//   oMERGED   out 32  iWORD with the target lane(s) replaced by iWDATA
module ram_lane_align
  import ram_access_pkg::*;
(
  input  logic [31:0] iWORD,
  input  logic [1:0]  iOFFSET,
  input  logic [1:0]  iSIZE,
  input  logic        iUNSIGNED,
  input  logic [31:0] iWDATA,
  output logic [31:0] oRDATA,
  output logic [31:0] oMERGED
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_wdata_rep;
  logic [3:0]  w_lane_hit;

  assign w_byte = iWORD[{iOFFSET, 3'b000} +: 8];
  assign w_half = iOFFSET[1] ? iWORD[31:16] : iWORD[15:0];

  always_comb begin
    oRDATA = iWORD;
    case (iSIZE)
      SZ_BYTE: oRDATA = {{24{~iUNSIGNED & w_byte[7]}}, w_byte};
      SZ_HALF: oRDATA = {{16{~iUNSIGNED & w_half[15]}}, w_half};
      default: oRDATA = iWORD;
    endcase
  end

  // Replicate the store data across every lane so each lane only has to
  // decide whether it takes the new byte or keeps the old one.
  always_comb begin
    w_wdata_rep = iWDATA;
    case (iSIZE)
      SZ_BYTE: w_wdata_rep = {4{iWDATA[7:0]}};
      SZ_HALF: w_wdata_rep = {2{iWDATA[15:0]}};
      default: w_wdata_rep = iWDATA;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_hit[gi] = (iSIZE == SZ_BYTE) ? (iOFFSET == 2'(gi)) :
                              (iSIZE == SZ_HALF) ? (iOFFSET[1] == 1'(gi >> 1)) :
                                                   1'b1;
      assign oMERGED[gi*8 +: 8] = w_lane_hit[gi] ? w_wdata_rep[gi*8 +: 8] : iWORD[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/ram_access_master.sv
// ram_access_master: turns LSU load/store requests into single-cycle RAM bus
// cycles. Byte/half stores are done as read-modify-write because the RAM only
// writes whole words.
//   iRAM_CLK/iRAM_RST            clock, asynchronous active-low reset
//   iLSU_REQ/WE/SIZE/UNSIGNED    request, sampled when oLSU_BUSY=0
//   iLSU_ADDR/iLSU_WDATA         byte address, right-justified store data
//   oLSU_BUSY/DONE/ERR/RDATA     in-flight flag, completion pulse, fault, load data
//   oRAM_CE/RD/WR/ADDR/DATA      RAM bus (word-aligned address)
//   iRAM_DATA                    RAM read data, valid in the CE&RD cycle
// Build option: define RAM_ACCESS_RANGE_CHECK_EN to fault addresses outside
// [RAM_ORIGIN, RAM_ORIGIN+RAM_LENGTH) at accept time.
module ram_access_master
  import ram_access_pkg::*;
#(
  parameter logic [31:0] RAM_ORIGIN = RAM_ORIGIN_DEF,
  parameter logic [31:0] RAM_LENGTH = RAM_LENGTH_DEF
) (
  input  logic        iRAM_CLK,
  input  logic        iRAM_RST,
  input  logic        iLSU_REQ,
  input  logic        iLSU_WE,
  input  logic [1:0]  iLSU_SIZE,
  input  logic        iLSU_UNSIGNED,
  input  logic [31:0] iLSU_ADDR,
  input  logic [31:0] iLSU_WDATA,
  output logic        oLSU_BUSY,
  output logic        oLSU_DONE,
  output logic        oLSU_ERR,
  output logic [31:0] oLSU_RDATA,
  output logic        oRAM_CE,
  output logic        oRAM_RD,
  output logic        oRAM_WR,
  output logic [31:0] oRAM_ADDR,
  output logic [31:0] oRAM_DATA,
  input  logic [31:0] iRAM_DATA
);

`ifdef RAM_ACCESS_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic        r_we;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [1:0]  r_byte_off;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_lsu_rdata;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_data;

  logic        w_accept;
  logic        w_fault;
  logic        w_out_of_range;
  logic [32:0] w_win_lo;
  logic [32:0] w_win_hi;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_accept = iLSU_REQ && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // 33-bit bounds so a window ending at 4 GiB does not wrap to zero.
  assign w_win_lo       = {1'b0, RAM_ORIGIN};
  assign w_win_hi       = {1'b0, RAM_ORIGIN} + {1'b0, RAM_LENGTH};
  assign w_out_of_range = ({1'b0, iLSU_ADDR} < w_win_lo) || ({1'b0, iLSU_ADDR} >= w_win_hi);

  assign w_fault = (iLSU_SIZE == SZ_RSVD) ||
                   misaligned(iLSU_SIZE, iLSU_ADDR[1:0]) ||
                   (RANGE_CHECK && w_out_of_range);

  always_ff @(posedge iRAM_CLK or negedge iRAM_RST) begin
    if (!iRAM_RST) r_state <= ST_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    oLSU_BUSY    = 1'b0;
    oLSU_DONE    = 1'b0;
    oRAM_CE      = 1'b0;
    oRAM_RD      = 1'b0;
    oRAM_WR      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        oLSU_DONE    = (r_state == ST_DONE);
        w_state_next = ST_IDLE;
        if (w_accept) begin
          if (w_fault)                                w_state_next = ST_DONE;
          else if (iLSU_WE && iLSU_SIZE == SZ_WORD)   w_state_next = ST_WRITE;
          else                                        w_state_next = ST_READ;
        end
      end
      ST_READ: begin
        oLSU_BUSY    = 1'b1;
        oRAM_CE      = 1'b1;
        oRAM_RD      = 1'b1;
        w_state_next = r_we ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: begin
        oLSU_BUSY    = 1'b1;
        oRAM_CE      = 1'b1;
        oRAM_WR      = 1'b1;
        w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  ram_lane_align u_align (
    .iWORD     (iRAM_DATA),
    .iOFFSET   (r_byte_off),
    .iSIZE     (r_size),
    .iUNSIGNED (r_unsigned),
    .iWDATA    (r_wdata),
    .oRDATA    (w_load_data),
    .oMERGED   (w_merged)
  );

  // Bus address/data registers only move when a bus cycle is about to
  // happen, so they hold their last values while the bus is idle.
  // oLSU_RDATA only changes on edges entering DONE, so it holds between DONEs.
  always_ff @(posedge iRAM_CLK or negedge iRAM_RST) begin
    if (!iRAM_RST) begin
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'b00;
      r_byte_off  <= 2'b00;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_lsu_rdata <= '0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_we       <= iLSU_WE;
            r_unsigned <= iLSU_UNSIGNED;
            r_size     <= iLSU_SIZE;
            r_byte_off <= iLSU_ADDR[1:0];
            r_wdata    <= iLSU_WDATA;
            r_err      <= w_fault;
            if (w_fault) begin
              r_lsu_rdata <= '0;
            end else begin
              r_ram_addr <= {iLSU_ADDR[31:2], 2'b00};
              if (iLSU_WE && iLSU_SIZE == SZ_WORD) r_ram_data <= iLSU_WDATA;
            end
          end
        end
        ST_READ: begin
          if (r_we) r_ram_data  <= w_merged;
          else      r_lsu_rdata <= w_load_data;
        end
        ST_WRITE: r_lsu_rdata <= '0;
        default: ;
      endcase
    end
  end

  assign oLSU_ERR   = oLSU_DONE && r_err;
  assign oLSU_RDATA = r_lsu_rdata;
  assign oRAM_ADDR  = r_ram_addr;
  assign oRAM_DATA  = r_ram_data;

endmodule

// File: tb/tb_ram_access_master.sv
module tb_ram_access_master;

  logic        clk;
  logic        rst_n;
  logic        iLSU_REQ, iLSU_WE, iLSU_UNSIGNED;
  logic [1:0]  iLSU_SIZE;
  logic [31:0] iLSU_ADDR, iLSU_WDATA;
  logic        oLSU_BUSY, oLSU_DONE, oLSU_ERR;
  logic [31:0] oLSU_RDATA;
  logic        oRAM_CE, oRAM_RD, oRAM_WR;
  logic [31:0] oRAM_ADDR, oRAM_DATA, iRAM_DATA;

  ram_access_master dut (
    .iRAM_CLK      (clk),
    .iRAM_RST      (rst_n),
    .iLSU_REQ      (iLSU_REQ),
    .iLSU_WE       (iLSU_WE),
    .iLSU_SIZE     (iLSU_SIZE),
    .iLSU_UNSIGNED (iLSU_UNSIGNED),
    .iLSU_ADDR     (iLSU_ADDR),
    .iLSU_WDATA    (iLSU_WDATA),
    .oLSU_BUSY     (oLSU_BUSY),
    .oLSU_DONE     (oLSU_DONE),
    .oLSU_ERR      (oLSU_ERR),
    .oLSU_RDATA    (oLSU_RDATA),
    .oRAM_CE       (oRAM_CE),
    .oRAM_RD       (oRAM_RD),
    .oRAM_WR       (oRAM_WR),
    .oRAM_ADDR     (oRAM_ADDR),
    .oRAM_DATA     (oRAM_DATA),
    .iRAM_DATA     (iRAM_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 64 words at 0x400..0x4FF, combinational read, write on edge.
  logic [31:0] mem [0:63];
  logic        preload;
  logic        in_win;
  assign in_win    = (oRAM_ADDR >= 32'h400) && (oRAM_ADDR < 32'h500);
  assign iRAM_DATA = (oRAM_CE && oRAM_RD && in_win) ? mem[oRAM_ADDR[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h8899AABB;
    end else if (oRAM_CE && oRAM_WR && in_win) begin
      mem[oRAM_ADDR[7:2]] <= oRAM_DATA;
    end
  end

  // Bus monitor: counts completed cycles, sampled at the edge that ends them.
  int          rd_cnt, wr_cnt, both_cnt, done_cnt;
  logic [31:0] wr_addr, wr_data;
  initial begin
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; done_cnt = 0;
    wr_addr = '0; wr_data = '0;
  end
  always @(posedge clk) begin
    if (oRAM_CE && oRAM_RD) rd_cnt++;
    if (oRAM_CE && oRAM_WR) begin
      wr_cnt++;
      wr_addr = oRAM_ADDR;
      wr_data = oRAM_DATA;
    end
    if (oRAM_RD && oRAM_WR) both_cnt++;
    if (oLSU_DONE) done_cnt++;
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;
  exp_t exp_q[$];

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request starting at a negedge and waits for its DONE pulse.
  // With pester set, a second request is held during READ/WRITE and must be
  // ignored. Returns at the negedge inside the DONE cycle.
  task automatic do_op(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input int exp_lat, input int exp_rd, input int exp_wr,
                       input bit pester);
    exp_t e, got;
    int   rd0, wr0;
    bit   seen;
    e.err = exp_err; e.rdata = exp_rdata; e.lat = exp_lat; e.rd = exp_rd; e.wr = exp_wr;
    exp_q.push_back(e);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    iLSU_REQ = 1'b1; iLSU_WE = we; iLSU_SIZE = size; iLSU_UNSIGNED = uns;
    iLSU_ADDR = addr; iLSU_WDATA = wdata;
    @(posedge clk);
    seen = 1'b0;
    for (int n = 1; n <= 8 && !seen; n++) begin
      @(negedge clk);
      if (oLSU_DONE) begin
        seen = 1'b1;
        got  = exp_q.pop_front();
        check({tag, "_lat"},   32'(n),            32'(got.lat));
        check({tag, "_err"},   32'(oLSU_ERR),     32'(got.err));
        check({tag, "_rdata"}, oLSU_RDATA,        got.rdata);
        check({tag, "_rd"},    32'(rd_cnt - rd0), 32'(got.rd));
        check({tag, "_wr"},    32'(wr_cnt - wr0), 32'(got.wr));
        iLSU_REQ = 1'b0;
      end else if (pester) begin
        iLSU_REQ = 1'b1; iLSU_WE = 1'b0; iLSU_SIZE = 2'b10; iLSU_ADDR = 32'h404;
      end else begin
        iLSU_REQ = 1'b0;
      end
    end
    if (!seen) begin
      void'(exp_q.pop_front());
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      iLSU_REQ = 1'b0;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  int d0, rd0, wr0;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; preload = 1'b1;
    iLSU_REQ = 1'b0; iLSU_WE = 1'b0; iLSU_SIZE = 2'b00; iLSU_UNSIGNED = 1'b0;
    iLSU_ADDR = '0; iLSU_WDATA = '0;
    idle(2);
    check("rst_ctl",   32'({oLSU_BUSY, oLSU_DONE, oLSU_ERR, oRAM_CE, oRAM_RD, oRAM_WR}), 32'h0);
    check("rst_rdata", oLSU_RDATA, 32'h0);
    check("rst_addr",  oRAM_ADDR,  32'h0);
    check("rst_data",  oRAM_DATA,  32'h0);
    preload = 1'b0;
    rst_n   = 1'b1;
    idle(1);

    // Loads over 0x8899AABB at 0x404.
    do_op("ld_b_s_405", 0, 2'b00, 0, 32'h405, 32'h0, 0, 32'hFFFFFFAA, 2, 1, 0, 0); idle(1);
    do_op("ld_b_u_405", 0, 2'b00, 1, 32'h405, 32'h0, 0, 32'h000000AA, 2, 1, 0, 0); idle(1);

    // Half store RMW.
    do_op("st_h_406", 1, 2'b01, 0, 32'h406, 32'h00001234, 0, 32'h0, 3, 1, 1, 0);
    check("st_h_406_waddr", wr_addr, 32'h404);
    check("st_h_406_wdata", wr_data, 32'h1234AABB);
    idle(1);
    do_op("ld_w_404", 0, 2'b10, 0, 32'h404, 32'h0, 0, 32'h1234AABB, 2, 1, 0, 0); idle(1);

    // Word store, then half loads from it.
    do_op("st_w_400", 1, 2'b10, 0, 32'h400, 32'hDEADBEEF, 0, 32'h0, 2, 0, 1, 0);
    check("st_w_400_waddr", wr_addr, 32'h400);
    check("st_w_400_wdata", wr_data, 32'hDEADBEEF);
    idle(1);
    do_op("ld_h_u_402", 0, 2'b01, 1, 32'h402, 32'h0, 0, 32'h0000DEAD, 2, 1, 0, 0); idle(1);
    do_op("ld_h_s_402", 0, 2'b01, 0, 32'h402, 32'h0, 0, 32'hFFFFDEAD, 2, 1, 0, 0); idle(1);

    // Byte store only touches its lane even with junk in the upper wdata bits.
    do_op("st_b_405", 1, 2'b00, 0, 32'h405, 32'hFFFFFF5A, 0, 32'h0, 3, 1, 1, 0);
    check("st_b_405_wdata", wr_data, 32'h12345ABB);
    idle(1);

    // Back-to-back chain: each request raised during the previous DONE cycle.
    do_op("ld_b_s_407", 0, 2'b00, 0, 32'h407, 32'h0, 0, 32'h00000012, 2, 1, 0, 0);
    do_op("b2b_ld_w",   0, 2'b10, 0, 32'h404, 32'h0, 0, 32'h12345ABB, 2, 1, 0, 0);
    do_op("b2b_mis_w",  0, 2'b10, 0, 32'h401, 32'h0, 1, 32'h0,        1, 0, 0, 0);
    do_op("b2b_rsvd",   1, 2'b11, 0, 32'h404, 32'h55, 1, 32'h0,       1, 0, 0, 0);
    idle(1);
    do_op("mis_h_403",  0, 2'b01, 0, 32'h403, 32'h0, 1, 32'h0,        1, 0, 0, 0); idle(1);

    // Requests held during READ/WRITE are ignored.
    do_op("pester_st_h", 1, 2'b01, 0, 32'h404, 32'h0000CAFE, 0, 32'h0, 3, 1, 1, 1);
    check("pester_wdata", wr_data, 32'h1234CAFE);
    d0 = done_cnt;
    idle(4);
    check("pester_one_done", 32'(done_cnt - d0), 32'd1);

    // Reset in the READ cycle of a byte store.
    rd0 = rd_cnt; wr0 = wr_cnt;
    iLSU_REQ = 1'b1; iLSU_WE = 1'b1; iLSU_SIZE = 2'b00; iLSU_UNSIGNED = 1'b0;
    iLSU_ADDR = 32'h404; iLSU_WDATA = 32'h77;
    @(posedge clk);
    @(negedge clk);
    iLSU_REQ = 1'b0;
    check("rstmid_in_read", 32'({oRAM_CE, oRAM_RD, oRAM_WR}), 32'b110);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_ctl",   32'({oLSU_BUSY, oLSU_DONE, oLSU_ERR, oRAM_CE, oRAM_RD, oRAM_WR}), 32'h0);
    check("rstmid_rdata", oLSU_RDATA, 32'h0);
    check("rstmid_addr",  oRAM_ADDR,  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("rstmid_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("rstmid_mem",   mem[1], 32'h1234CAFE);
    do_op("post_rst_ld_w", 0, 2'b10, 0, 32'h404, 32'h0, 0, 32'h1234CAFE, 2, 1, 0, 0);
    idle(3);
    check("rdata_hold", oLSU_RDATA, 32'h1234CAFE);

    // Address outside the RAM window.
`ifdef RAM_ACCESS_RANGE_CHECK_EN
    do_op("ld_w_500", 0, 2'b10, 0, 32'h500, 32'h0, 1, 32'h0, 1, 0, 0, 0);
`else
    do_op("ld_w_500", 0, 2'b10, 0, 32'h500, 32'h0, 0, 32'h0, 2, 1, 0, 0);
`endif
    idle(2);

    check("rd_wr_never_together", 32'(both_cnt), 32'd0);
    check("scoreboard_empty",     32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
